// File: rtl/rv32i_redirect_ctrl.sv
// RV32I control-flow redirect and load-use hazard controller.
// Holds the ID/EX register, resolves branches/jumps in EX and sequences stall and flush cycles.
module rv32i_redirect_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [6:0]  id_opcode,
    input  logic [2:0]  id_funct3,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    output logic        id_ctrl_flag,
    output logic        ex_ctrl_flag,
    output logic        ex_jump_flag,
    output logic [31:0] ex_offset,
    output logic [31:0] ex_jump_pc,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic [31:0] ex_link_data,
    output logic [4:0]  ex_link_rd,
    output logic        misalign_err,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    state_t      state_q, state_d;

    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;

    logic [31:0] redirect_cnt_q;
    logic [31:0] stall_cnt_q;

    logic        id_live;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        load_use;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        branch_taken;
    logic        ex_active;
    logic        take_rel;
    logic        take_abs;
    logic        redirect;
    logic        stall;
    logic        is_link;
    logic [31:0] rel_target;
    logic [31:0] abs_target;

    // The word IMEM delivers during FLUSH is stale, so ID is ignored then.
    assign id_live     = id_valid && (state_q != FLUSH);
    assign id_uses_rs1 = !((id_opcode == OPC_JAL) || (id_opcode == OPC_LUI) ||
                           (id_opcode == OPC_AUIPC));
    assign id_uses_rs2 = (id_opcode == OPC_BRANCH) || (id_opcode == OPC_STORE) ||
                         (id_opcode == OPC_OP);

    assign load_use = ex_valid && (ex_opcode == OPC_LOAD) && (ex_rd != 5'd0) && id_live &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign ex_is_branch = (ex_opcode == OPC_BRANCH);
    assign ex_is_jal    = (ex_opcode == OPC_JAL);
    assign ex_is_jalr   = (ex_opcode == OPC_JALR);

    always_comb begin
        // NOTE: default first so every path assigns branch_taken and no latch is inferred.
        branch_taken = 1'b0;
        case (ex_funct3)
            3'b000:  branch_taken = (ex_rs1_data == ex_rs2_data);
            3'b001:  branch_taken = (ex_rs1_data != ex_rs2_data);
            3'b100:  branch_taken = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
            3'b101:  branch_taken = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
            3'b110:  branch_taken = (ex_rs1_data <  ex_rs2_data);
            3'b111:  branch_taken = (ex_rs1_data >= ex_rs2_data);
            default: branch_taken = 1'b0;
        endcase
    end

    // Reset is synchronous, so outputs are gated by rst to be quiet during the reset cycle itself.
    assign ex_active  = ex_valid && (state_q != FLUSH) && !rst;
    assign take_rel   = ex_active && ((ex_is_branch && branch_taken) || ex_is_jal);
    assign take_abs   = ex_active && ex_is_jalr;
    assign redirect   = take_rel || take_abs;
    assign stall      = !rst && (state_q == RUN) && load_use && !redirect;
    assign is_link    = ex_active && (ex_is_jal || ex_is_jalr);

    assign rel_target = ex_pc + ex_imm;
    assign abs_target = (ex_rs1_data + ex_imm) & 32'hFFFF_FFFE;

    assign id_ctrl_flag = stall;
    assign ex_ctrl_flag = take_rel;
    assign ex_jump_flag = take_abs;
    // IF already runs two words ahead of EX, hence the -8 on the pc-relative offset.
    assign ex_offset    = take_rel ? (ex_imm - 32'd8) : 32'd0;
    assign ex_jump_pc   = take_abs ? abs_target : 32'd0;
    assign flush_ifid   = !rst && (redirect || (state_q == FLUSH));
    assign flush_idex   = flush_ifid;
    assign ex_link_data = is_link ? (ex_pc + 32'd4) : 32'd0;
    assign ex_link_rd   = is_link ? ex_rd : 5'd0;
    assign misalign_err = (take_rel && rel_target[1]) || (take_abs && abs_target[1]);
    assign redirect_cnt = rst ? 32'd0 : redirect_cnt_q;
    assign stall_cnt    = rst ? 32'd0 : stall_cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (redirect)   state_d = FLUSH;
                else if (stall) state_d = STALL;
            end
            STALL:   state_d = redirect ? FLUSH : RUN;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state_q        <= RUN;
            ex_valid       <= 1'b0;
            ex_opcode      <= 7'd0;
            ex_funct3      <= 3'd0;
            ex_pc          <= 32'd0;
            ex_imm         <= 32'd0;
            ex_rs1_data    <= 32'd0;
            ex_rs2_data    <= 32'd0;
            ex_rd          <= 5'd0;
            redirect_cnt_q <= 32'd0;
            stall_cnt_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            ex_valid    <= id_live && !redirect && !stall;
            ex_opcode   <= id_opcode;
            ex_funct3   <= id_funct3;
            ex_pc       <= id_pc;
            ex_imm      <= id_imm;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_rd       <= id_rd;
            if (redirect) redirect_cnt_q <= redirect_cnt_q + 32'd1;
            if (stall)    stall_cnt_q    <= stall_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_rv32i_redirect_ctrl.sv
// Self-checking bench for rv32i_redirect_ctrl: vector table through a scoreboard queue,
// plus hand sequences for load-use, redirect-over-stall, reset and counter wrap.
module tb_rv32i_redirect_ctrl;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic        id_ctrl_flag, ex_ctrl_flag, ex_jump_flag;
    logic [31:0] ex_offset, ex_jump_pc;
    logic        flush_ifid, flush_idex;
    logic [31:0] ex_link_data;
    logic [4:0]  ex_link_rd;
    logic        misalign_err;
    logic [31:0] redirect_cnt, stall_cnt;

    rv32i_redirect_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_funct3    (id_funct3),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_pc        (id_pc),
        .id_imm       (id_imm),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .id_ctrl_flag (id_ctrl_flag),
        .ex_ctrl_flag (ex_ctrl_flag),
        .ex_jump_flag (ex_jump_flag),
        .ex_offset    (ex_offset),
        .ex_jump_pc   (ex_jump_pc),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .ex_link_data (ex_link_data),
        .ex_link_rd   (ex_link_rd),
        .misalign_err (misalign_err),
        .redirect_cnt (redirect_cnt),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic        ctrl;
        logic        jump;
        logic [31:0] offset;
        logic [31:0] jump_pc;
        logic        mis;
        logic [31:0] link_data;
        logic [4:0]  link_rd;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];
    vec_t sb [$];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_redir = 0;
    int exp_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic ctrl, input logic jump, input logic [31:0] off,
                                input logic [31:0] jpc, input logic mis,
                                input logic [31:0] ld, input logic [4:0] lrd);
        vec_t v;
        v.opcode = opc; v.funct3 = f3; v.rd = rd; v.pc = pc; v.imm = imm;
        v.rs1_data = a; v.rs2_data = b; v.ctrl = ctrl; v.jump = jump; v.offset = off;
        v.jump_pc = jpc; v.mis = mis; v.link_data = ld; v.link_rd = lrd;
        return v;
    endfunction

    task automatic drive_idle();
        id_valid = 1'b0; id_opcode = 7'd0; id_funct3 = 3'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        id_pc = 32'd0; id_imm = 32'd0; id_rs1_data = 32'd0; id_rs2_data = 32'd0;
    endtask

    task automatic drive_insn(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] pc,
                              input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b);
        id_valid = 1'b1; id_opcode = opc; id_funct3 = f3;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_pc = pc; id_imm = imm; id_rs1_data = a; id_rs2_data = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " id_ctrl_flag"}, 32'(id_ctrl_flag), 32'd0);
        check({tag, " ex_ctrl_flag"}, 32'(ex_ctrl_flag), 32'd0);
        check({tag, " ex_jump_flag"}, 32'(ex_jump_flag), 32'd0);
        check({tag, " ex_offset"}, ex_offset, 32'd0);
        check({tag, " ex_jump_pc"}, ex_jump_pc, 32'd0);
        check({tag, " flush_ifid"}, 32'(flush_ifid), 32'd0);
        check({tag, " flush_idex"}, 32'(flush_idex), 32'd0);
        check({tag, " ex_link_data"}, ex_link_data, 32'd0);
        check({tag, " ex_link_rd"}, 32'(ex_link_rd), 32'd0);
        check({tag, " misalign_err"}, 32'(misalign_err), 32'd0);
        check({tag, " redirect_cnt"}, redirect_cnt, 32'd0);
        check({tag, " stall_cnt"}, stall_cnt, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        logic redir;

        //           opcode      f3      rd     pc            imm           rs1_data      rs2_data      ctrl  jump  offset        jump_pc       mis   link_data    link_rd
        vecs[0]  = mk(OPC_BRANCH, 3'b000, 5'd0, 32'h0000_0100, 32'h0000_0020, 32'd5,        32'd5,        1'b1, 1'b0, 32'h0000_0018, 32'd0,        1'b0, 32'd0,        5'd0);
        vecs[1]  = mk(OPC_BRANCH, 3'b001, 5'd0, 32'h0000_0104, 32'h0000_0020, 32'd5,        32'd5,        1'b0, 1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        5'd0);
        vecs[2]  = mk(OPC_BRANCH, 3'b100, 5'd0, 32'h0000_0200, 32'h0000_0010, 32'hFFFF_FFFF, 32'd1,       1'b1, 1'b0, 32'h0000_0008, 32'd0,        1'b0, 32'd0,        5'd0);
        vecs[3]  = mk(OPC_BRANCH, 3'b110, 5'd0, 32'h0000_0200, 32'h0000_0010, 32'hFFFF_FFFF, 32'd1,       1'b0, 1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        5'd0);
        vecs[4]  = mk(OPC_BRANCH, 3'b101, 5'd0, 32'h0000_0300, 32'hFFFF_FFF0, 32'd1,        32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFE8, 32'd0,        1'b0, 32'd0,        5'd0);
        vecs[5]  = mk(OPC_BRANCH, 3'b111, 5'd0, 32'h0000_0300, 32'hFFFF_FFF0, 32'd1,        32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        5'd0);
        vecs[6]  = mk(OPC_BRANCH, 3'b010, 5'd0, 32'h0000_0400, 32'h0000_0020, 32'd7,        32'd7,        1'b0, 1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        5'd0);
        vecs[7]  = mk(OPC_JAL,    3'b000, 5'd5, 32'h0000_0080, 32'h0000_0102, 32'd0,        32'd0,        1'b1, 1'b0, 32'h0000_00FA, 32'd0,        1'b1, 32'h0000_0084, 5'd5);
        vecs[8]  = mk(OPC_JALR,   3'b000, 5'd1, 32'h0000_0040, 32'h0000_0004, 32'h0000_2003, 32'd0,       1'b0, 1'b1, 32'd0,        32'h0000_2006, 1'b1, 32'h0000_0044, 5'd1);
        vecs[9]  = mk(OPC_JALR,   3'b000, 5'd0, 32'h0000_0500, 32'hFFFF_FF01, 32'h0000_1000, 32'd0,       1'b0, 1'b1, 32'd0,        32'h0000_0F00, 1'b0, 32'h0000_0504, 5'd0);
        vecs[10] = mk(OPC_OP,     3'b000, 5'd4, 32'h0000_0600, 32'd0,        32'd9,        32'd9,        1'b0, 1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        5'd0);
        vecs[11] = mk(OPC_BRANCH, 3'b000, 5'd0, 32'h0000_0700, 32'h0000_0006, 32'h10,       32'h11,       1'b0, 1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        5'd0);
        vecs[12] = mk(OPC_BRANCH, 3'b001, 5'd0, 32'h0000_0700, 32'h0000_0006, 32'h10,       32'h11,       1'b1, 1'b0, 32'hFFFF_FFFE, 32'd0,        1'b1, 32'd0,        5'd0);

        // Reset state: drive a JAL into ID while reset is held; nothing may leak out.
        rst = 1'b1;
        drive_insn(OPC_JAL, 3'b000, 5'd0, 5'd0, 5'd1, 32'h10, 32'h20, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        check("reset state", 32'(dut.state_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        #1;
        check_all_zero("post-reset first cycle");

        // Table-driven vectors through the scoreboard.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive_insn(vecs[i].opcode, vecs[i].funct3, 5'd1, 5'd2, vecs[i].rd, vecs[i].pc,
                       vecs[i].imm, vecs[i].rs1_data, vecs[i].rs2_data);
            sb.push_back(vecs[i]);
            @(negedge clk);
            drive_idle();
            #1;
            e = sb.pop_front();
            redir = e.ctrl | e.jump;
            check($sformatf("v%0d ex_ctrl_flag", i), 32'(ex_ctrl_flag), 32'(e.ctrl));
            check($sformatf("v%0d ex_jump_flag", i), 32'(ex_jump_flag), 32'(e.jump));
            check($sformatf("v%0d ex_offset", i), ex_offset, e.offset);
            check($sformatf("v%0d ex_jump_pc", i), ex_jump_pc, e.jump_pc);
            check($sformatf("v%0d misalign_err", i), 32'(misalign_err), 32'(e.mis));
            check($sformatf("v%0d ex_link_data", i), ex_link_data, e.link_data);
            check($sformatf("v%0d ex_link_rd", i), 32'(ex_link_rd), 32'(e.link_rd));
            check($sformatf("v%0d flush_ifid", i), 32'(flush_ifid), 32'(redir));
            check($sformatf("v%0d flush_idex", i), 32'(flush_idex), 32'(redir));
            check($sformatf("v%0d id_ctrl_flag", i), 32'(id_ctrl_flag), 32'd0);
            if (redir) exp_redir++;
            @(negedge clk);
            #1;
            check($sformatf("v%0d next state", i), 32'(dut.state_q), redir ? 32'd2 : 32'd0);
            check($sformatf("v%0d next flush_ifid", i), 32'(flush_ifid), 32'(redir));
            check($sformatf("v%0d next misalign_err", i), 32'(misalign_err), 32'd0);
            check($sformatf("v%0d redirect_cnt", i), redirect_cnt, 32'(exp_redir));
        end

        // Load-use: LW x3 in EX, ADD using x3 as rs2 in ID.
        @(negedge clk);
        drive_insn(OPC_LOAD, 3'b010, 5'd1, 5'd0, 5'd3, 32'h800, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        drive_insn(OPC_OP, 3'b000, 5'd2, 5'd3, 5'd4, 32'h804, 32'd0, 32'd0, 32'd0);
        #1;
        check("lu id_ctrl_flag", 32'(id_ctrl_flag), 32'd1);
        check("lu flush_ifid", 32'(flush_ifid), 32'd0);
        exp_stall++;
        @(negedge clk);
        #1;
        check("lu stall one cycle", 32'(id_ctrl_flag), 32'd0);
        check("lu state STALL", 32'(dut.state_q), 32'd1);
        check("lu stall_cnt", stall_cnt, 32'(exp_stall));
        check("lu bubble in EX", 32'(dut.ex_valid), 32'd0);
        @(negedge clk);
        drive_idle();
        #1;
        check("lu ADD in EX valid", 32'(dut.ex_valid), 32'd1);
        check("lu ADD in EX opcode", 32'(dut.ex_opcode), 32'(OPC_OP));
        check("lu state RUN", 32'(dut.state_q), 32'd0);

        // LUI does not read rs1, so a matching rs1 field must not stall.
        @(negedge clk);
        drive_insn(OPC_LOAD, 3'b010, 5'd1, 5'd0, 5'd3, 32'h900, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        drive_insn(OPC_LUI, 3'b000, 5'd3, 5'd3, 5'd6, 32'h904, 32'h1000, 32'd0, 32'd0);
        #1;
        check("lui no stall", 32'(id_ctrl_flag), 32'd0);
        @(negedge clk);
        drive_idle();
        #1;
        check("lui stall_cnt", stall_cnt, 32'(exp_stall));

        // Redirect beats stall: taken BNE in EX while the load/consumer pair is behind it.
        @(negedge clk);
        drive_insn(OPC_BRANCH, 3'b001, 5'd1, 5'd2, 5'd0, 32'h600, 32'h40, 32'd1, 32'd2);
        @(negedge clk);
        drive_insn(OPC_LOAD, 3'b010, 5'd1, 5'd0, 5'd3, 32'h604, 32'd0, 32'd0, 32'd0);
        #1;
        check("rvs ex_ctrl_flag", 32'(ex_ctrl_flag), 32'd1);
        check("rvs ex_offset", ex_offset, 32'h38);
        check("rvs id_ctrl_flag", 32'(id_ctrl_flag), 32'd0);
        check("rvs flush_idex", 32'(flush_idex), 32'd1);
        exp_redir++;
        @(negedge clk);
        drive_insn(OPC_OP, 3'b000, 5'd2, 5'd3, 5'd4, 32'h608, 32'd0, 32'd0, 32'd0);
        #1;
        check("rvs flush state", 32'(dut.state_q), 32'd2);
        check("rvs flush id_ctrl_flag", 32'(id_ctrl_flag), 32'd0);
        check("rvs flush flush_ifid", 32'(flush_ifid), 32'd1);
        @(negedge clk);
        drive_idle();
        #1;
        check("rvs stall_cnt", stall_cnt, 32'(exp_stall));
        check("rvs redirect_cnt", redirect_cnt, 32'(exp_redir));
        check("rvs stale dropped", 32'(dut.ex_valid), 32'd0);

        // Reset asserted in a JAL redirect cycle.
        @(negedge clk);
        drive_insn(OPC_JAL, 3'b000, 5'd0, 5'd0, 5'd1, 32'h80, 32'h100, 32'd0, 32'd0);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        #1;
        check_all_zero("rst in redirect");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("after rst");
        check("after rst state", 32'(dut.state_q), 32'd0);
        exp_redir = 0;
        exp_stall = 0;

        // Counter wrap: preset redirect count to all-ones, one redirect wraps it to zero.
        @(negedge clk);
        force dut.redirect_cnt_q = 32'hFFFF_FFFF;
        drive_insn(OPC_JAL, 3'b000, 5'd0, 5'd0, 5'd0, 32'h40, 32'h10, 32'd0, 32'd0);
        #1;
        release dut.redirect_cnt_q;
        @(negedge clk);
        drive_idle();
        #1;
        check("wrap pre redirect_cnt", redirect_cnt, 32'hFFFF_FFFF);
        check("wrap ex_ctrl_flag", 32'(ex_ctrl_flag), 32'd1);
        @(negedge clk);
        #1;
        check("wrap redirect_cnt", redirect_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
